// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: boot hold, load-use stall, redirect flush, halt drain/freeze.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int BOOT_CYCLES  = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memr,
  input  logic             ex_pc_src,
  input  logic             halt_req,
  output logic             halt_ack,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int BOOT_W  = $clog2(BOOT_CYCLES) + 1;
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [BOOT_W-1:0]  BOOT_LAST  = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  if (BOOT_CYCLES < 1 || DRAIN_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipeline_hazard_ctrl: BOOT_CYCLES, DRAIN_CYCLES and CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  state_e               state_q, state_d;
  logic [BOOT_W-1:0]    boot_cnt_q, boot_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                 halt_ack_q, halt_ack_d;
  logic                 load_use;

  // A load writing x0 never creates a real dependency.
  assign load_use = ex_memr && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    drain_cnt_d = drain_cnt_q;
    halt_ack_d  = halt_ack_q;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_write = 1'b0;
    id_ex_flush = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = ST_RUN;
          boot_cnt_d = '0;
        end else begin
          boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (ex_pc_src) begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
          id_ex_write = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          id_ex_write = 1'b1;
          id_ex_flush = 1'b1;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          id_ex_write = 1'b1;
        end
        if (halt_req) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end

      ST_DRAIN: begin
        id_ex_write = 1'b1;
        id_ex_flush = 1'b1;
        // A redirect resolving during drain still latches its target and kills the wrong path.
        if (ex_pc_src) begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
        end
        if (!halt_req) begin
          state_d     = ST_RUN;
          drain_cnt_d = '0;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = ST_HALTED;
          drain_cnt_d = '0;
          halt_ack_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end

      ST_HALTED: begin
        if (!halt_req) begin
          state_d    = ST_RUN;
          halt_ack_d = 1'b0;
        end
      end

      default: begin
        state_d     = ST_BOOT;
        boot_cnt_d  = '0;
        drain_cnt_d = '0;
        halt_ack_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= '0;
      drain_cnt_q <= '0;
      halt_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      halt_ack_q  <= halt_ack_d;
    end
  end

  assign halt_ack = halt_ack_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_inc, flush_inc;

  assign stall_inc = (state_q == ST_RUN) && load_use && !ex_pc_src;
  assign flush_inc = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && ex_pc_src;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: boot hold, stalls, redirects, halt drain/freeze.
// Counter checks are compiled in only when HAZ_PERF_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             ex_memr, ex_pc_src, halt_req;
  logic             halt_ack, pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, halt_ack}
  localparam logic [5:0] V_OFF  = 6'b000000;
  localparam logic [5:0] V_NORM = 6'b110100;
  localparam logic [5:0] V_BUB  = 6'b000110;
  localparam logic [5:0] V_RED  = 6'b111110;
  localparam logic [5:0] V_HALT = 6'b000001;

  pipeline_hazard_ctrl #(
    .BOOT_CYCLES (4),
    .DRAIN_CYCLES(3),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_rd      (ex_rd),
    .ex_memr    (ex_memr),
    .ex_pc_src  (ex_pc_src),
    .halt_req   (halt_req),
    .halt_ack   (halt_ack),
    .pc_write   (pc_write),
    .if_id_write(if_id_write),
    .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write),
    .id_ex_flush(id_ex_flush)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, halt_ack};
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] obs,
                         input logic [CNT_W-1:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic drive(input logic memr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic pc_src, input logic hreq);
    ex_memr   = memr;
    ex_rd     = rd;
    id_rs1    = rs1;
    id_rs2    = rs2;
    ex_pc_src = pc_src;
    halt_req  = hreq;
  endtask

  // Advance to the next falling edge, apply inputs, let them settle before sampling.
  task automatic step(input logic memr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic pc_src, input logic hreq);
    @(negedge clk);
    drive(memr, rd, rs1, rs2, pc_src, hreq);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("in_reset", V_OFF);

    // 1. Boot hold: exactly four frozen cycles, then normal flow.
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("boot_c1", V_OFF);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk("boot_c2", V_OFF);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk("boot_c3", V_OFF);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk("boot_c4", V_OFF);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk("run_first", V_NORM);

    // 2. Load-use on rs2, then release.
    step(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0); chk("lu_rs2", V_BUB);
    step(1'b0, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0); chk("lu_clear", V_NORM);
`ifdef HAZ_PERF_CNT_EN
    chk_cnt("stall_cnt_1", stall_cnt, 1);
`endif
    // Persisting hazard on rs1 stalls every cycle.
    step(1'b1, 5'd9, 5'd9, 5'd1, 1'b0, 1'b0); chk("lu_rs1_a", V_BUB);
    step(1'b1, 5'd9, 5'd9, 5'd1, 1'b0, 1'b0); chk("lu_rs1_b", V_BUB);

    // 3. Load to x0 is not a hazard; redirect beats load-use.
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk("lu_x0", V_NORM);
`ifdef HAZ_PERF_CNT_EN
    chk_cnt("stall_cnt_3", stall_cnt, 3);
`endif
    step(1'b1, 5'd7, 5'd7, 5'd2, 1'b1, 1'b0); chk("redir_over_lu", V_RED);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk("after_redir", V_NORM);
`ifdef HAZ_PERF_CNT_EN
    chk_cnt("stall_cnt_keep", stall_cnt, 3);
    chk_cnt("flush_cnt_1", flush_cnt, 1);
`endif

    // 4. Halt: three bubbles, then frozen with ack; release back to RUN.
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk("halt_req_run", V_NORM);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk("drain_c1", V_BUB);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk("drain_c2", V_BUB);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk("drain_c3", V_BUB);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk("halted_a", V_HALT);
    // Hazard inputs must not disturb the frozen pipeline.
    step(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1); chk("halted_b", V_HALT);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk("halted_release", V_HALT);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk("run_after_halt", V_NORM);
`ifdef HAZ_PERF_CNT_EN
    chk_cnt("flush_cnt_halted", flush_cnt, 1);
`endif

    // 5. Redirect in drain cycle 2 does not delay halt_ack.
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk("h2_run", V_NORM);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk("h2_drain_c1", V_BUB);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1); chk("h2_drain_c2_redir", V_RED);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk("h2_drain_c3", V_BUB);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk("h2_halted", V_HALT);
`ifdef HAZ_PERF_CNT_EN
    chk_cnt("flush_cnt_drain", flush_cnt, 2);
`endif

    // 6. Asynchronous reset in the middle of a drain.
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk("h2_release", V_HALT);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk("h3_run", V_NORM);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk("h3_drain_c1", V_BUB);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk("h3_drain_c2", V_BUB);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", V_OFF);
`ifdef HAZ_PERF_CNT_EN
    chk_cnt("stall_cnt_rst", stall_cnt, 0);
    chk_cnt("flush_cnt_rst", flush_cnt, 0);
`endif
    // halt_req held through boot is ignored until RUN.
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("boot2_c1", V_OFF);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk("boot2_c2", V_OFF);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk("boot2_c3", V_OFF);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk("boot2_c4", V_OFF);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk("boot2_run", V_NORM);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); chk("h4_drain_c1", V_BUB);
    // Dropping halt_req mid-drain: IF_ID held unflushed, back to RUN next cycle.
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk("h4_abort", V_BUB);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); chk("h4_run", V_NORM);
    step(1'b1, 5'd6, 5'd0, 5'd6, 1'b0, 1'b0); chk("h4_lu", V_BUB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
